// File: rtl/nyakuo_pkg.sv
// Shared types for the decode stage: decoded op enum, opcode/funct7 constants,
// the decoded bundle carried through the skid registers, and the skid FSM states.
package nyakuo_pkg;

   typedef enum logic [3:0] {
      NOP, SLL, SRL, SRA, XOR, OR, AND,
      SLLI, SRLI, SRAI, XORI, ORI, ANDI
   } instruction;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_BASE    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      instruction  inst;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        illegal;
   } decoded_t;

   localparam decoded_t DECODED_RESET = '{inst: NOP, a: 32'h0, b: 32'h0, rd: 5'h0, illegal: 1'b0};

   typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

endpackage

// File: rtl/decode_stage_inst_decoder.sv
// Combinational RV32I shift/logic decoder: raw word plus register data in,
// decoded_t bundle and register read addresses out.
module inst_decoder
   import nyakuo_pkg::*;
(
   input  logic [31:0] word,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   output logic [4:0]  rs1_addr,
   output logic [4:0]  rs2_addr,
   output decoded_t    dec
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [11:0] imm;
   instruction inst;
   logic is_imm_shift;

   assign opcode   = word[6:0];
   assign funct3   = word[14:12];
   assign funct7   = word[31:25];
   assign imm      = word[31:20];
   assign rs1_addr = word[19:15];
   assign rs2_addr = word[24:20];

   always_comb begin
      inst = NOP;
      case (opcode)
         OPC_OP: begin
            case (funct3)
               3'b001: if (funct7 == F7_BASE) inst = SLL;
               3'b100: if (funct7 == F7_BASE) inst = XOR;
               3'b110: if (funct7 == F7_BASE) inst = OR;
               3'b111: if (funct7 == F7_BASE) inst = AND;
               3'b101: begin
                  if (funct7 == F7_BASE)     inst = SRL;
                  else if (funct7 == F7_ALT) inst = SRA;
               end
               default: inst = NOP;
            endcase
         end
         OPC_OP_IMM: begin
            // imm[11:5] occupies the funct7 field for the immediate shifts
            case (funct3)
               3'b100: inst = XORI;
               3'b110: inst = ORI;
               3'b111: inst = ANDI;
               3'b001: if (funct7 == F7_BASE) inst = SLLI;
               3'b101: begin
                  if (funct7 == F7_BASE)     inst = SRLI;
                  else if (funct7 == F7_ALT) inst = SRAI;
               end
               default: inst = NOP;
            endcase
         end
         default: inst = NOP;
      endcase
   end

   assign is_imm_shift = (inst == SLLI) || (inst == SRLI) || (inst == SRAI);

   always_comb begin
      dec    = DECODED_RESET;
      dec.rd = word[11:7];
      if (inst == NOP) begin
         dec.illegal = 1'b1;
      end else begin
         dec.inst = inst;
         dec.a    = rs1_data;
         if (opcode == OPC_OP)  dec.b = rs2_data;
         else if (is_imm_shift) dec.b = {27'b0, imm[4:0]};
         else                   dec.b = {{20{imm[11]}}, imm};
      end
   end

endmodule

// File: rtl/decode_stage.sv
// Decode stage between fetch and ALU: valid/ready pipeline register with an
// optional 2-entry skid so that in_ready_o comes straight from a flop.
//
// state | meaning
// EMPTY | nothing held, out_valid_o=0
// ONE   | output register holds an op
// TWO   | output register and skid register both hold ops, in_ready_o=0
module decode_stage
   import nyakuo_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter bit SKID_EN = 1'b1
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            flush_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     in_inst_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output instruction      out_inst_o,
   output logic [XLEN-1:0] out_operand_a_o,
   output logic [XLEN-1:0] out_operand_b_o,
   output logic [4:0]      out_rd_o,
   output logic            out_illegal_o
);

   skid_state_t state, state_next;
   logic ready_q;
   logic in_fire, out_fire;
   logic load_out_dec, load_out_skid, load_skid;
   decoded_t dec, out_q, skid_q;

   inst_decoder u_inst_decoder (
      .word     (in_inst_i),
      .rs1_data (rs1_data_i),
      .rs2_data (rs2_data_i),
      .rs1_addr (rs1_addr_o),
      .rs2_addr (rs2_addr_o),
      .dec      (dec)
   );

   assign out_valid_o = (state != EMPTY);
   assign in_ready_o  = SKID_EN ? ready_q : ((state == EMPTY) || out_ready_i);
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = out_valid_o & out_ready_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state   <= EMPTY;
         ready_q <= 1'b1;
      end else begin
         state   <= state_next;
         ready_q <= (state_next != TWO);
      end
   end

   always_comb begin
      state_next    = state;
      load_out_dec  = 1'b0;
      load_out_skid = 1'b0;
      load_skid     = 1'b0;
      if (flush_i) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_fire) begin
                  state_next   = ONE;
                  load_out_dec = 1'b1;
               end
            end
            ONE: begin
               if (in_fire && !out_fire) begin
                  state_next = TWO;
                  load_skid  = 1'b1;
               end else if (out_fire && !in_fire) begin
                  state_next = EMPTY;
               end else if (in_fire && out_fire) begin
                  load_out_dec = 1'b1;
               end
            end
            TWO: begin
               if (out_fire) begin
                  state_next    = ONE;
                  load_out_skid = 1'b1;
               end
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         out_q  <= DECODED_RESET;
         skid_q <= DECODED_RESET;
      end else begin
         if (load_out_dec)       out_q <= dec;
         else if (load_out_skid) out_q <= skid_q;
         if (load_skid)          skid_q <= dec;
      end
   end

   assign out_inst_o      = out_q.inst;
   assign out_operand_a_o = out_q.a;
   assign out_operand_b_o = out_q.b;
   assign out_rd_o        = out_q.rd;
   assign out_illegal_o   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode vectors, backpressure
// through the skid, flush and mid-traffic reset.
module tb_decode_stage;
   import nyakuo_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [31:0] in_inst_i = 32'h0;
   logic [4:0]  rs1_addr_o, rs2_addr_o;
   logic [31:0] rs1_data_i = 32'h0;
   logic [31:0] rs2_data_i = 32'h0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   instruction  out_inst_o;
   logic [31:0] out_operand_a_o, out_operand_b_o;
   logic [4:0]  out_rd_o;
   logic        out_illegal_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .flush_i         (flush_i),
      .in_valid_i      (in_valid_i),
      .in_ready_o      (in_ready_o),
      .in_inst_i       (in_inst_i),
      .rs1_addr_o      (rs1_addr_o),
      .rs2_addr_o      (rs2_addr_o),
      .rs1_data_i      (rs1_data_i),
      .rs2_data_i      (rs2_data_i),
      .out_valid_o     (out_valid_o),
      .out_ready_i     (out_ready_i),
      .out_inst_o      (out_inst_o),
      .out_operand_a_o (out_operand_a_o),
      .out_operand_b_o (out_operand_b_o),
      .out_rd_o        (out_rd_o),
      .out_illegal_o   (out_illegal_o)
   );

   typedef struct {
      logic [31:0] word;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [4:0]  a1;
      logic [4:0]  a2;
      instruction  inst;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [31:0] w, input logic [31:0] r1, input logic [31:0] r2);
      in_valid_i = 1'b1;
      in_inst_i  = w;
      rs1_data_i = r1;
      rs2_data_i = r2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"},   out_valid_o, 32'd0);
      chk({tag, "_ready"},   in_ready_o, 32'd1);
      chk({tag, "_inst"},    out_inst_o, NOP);
      chk({tag, "_a"},       out_operand_a_o, 32'h0);
      chk({tag, "_b"},       out_operand_b_o, 32'h0);
      chk({tag, "_rd"},      out_rd_o, 32'd0);
      chk({tag, "_illegal"}, out_illegal_o, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{32'h00209133, 32'h00000001, 32'h00000004, 5'd1, 5'd2,  SLL,  32'h00000001, 32'h00000004, 5'd2, 1'b0};
      vecs[1]  = '{32'h40335293, 32'h80000000, 32'h12345678, 5'd6, 5'd3,  SRAI, 32'h80000000, 32'h00000003, 5'd5, 1'b0};
      vecs[2]  = '{32'hFFF07093, 32'h00000000, 32'h00000055, 5'd0, 5'd31, ANDI, 32'h00000000, 32'hFFFFFFFF, 5'd1, 1'b0};
      vecs[3]  = '{32'h00000000, 32'h00000011, 32'h00000022, 5'd0, 5'd0,  NOP,  32'h00000000, 32'h00000000, 5'd0, 1'b1};
      vecs[4]  = '{32'h0020C1B3, 32'hF0F0F0F0, 32'h0FF00FF0, 5'd1, 5'd2,  XOR,  32'hF0F0F0F0, 32'h0FF00FF0, 5'd3, 1'b0};
      vecs[5]  = '{32'h4020D233, 32'hAAAA5555, 32'h0000001F, 5'd1, 5'd2,  SRA,  32'hAAAA5555, 32'h0000001F, 5'd4, 1'b0};
      vecs[6]  = '{32'hFF00E393, 32'h00001234, 32'h00000009, 5'd1, 5'd16, ORI,  32'h00001234, 32'hFFFFFFF0, 5'd7, 1'b0};
      vecs[7]  = '{32'h01F0D093, 32'h00000005, 32'h00000006, 5'd1, 5'd31, SRLI, 32'h00000005, 32'h0000001F, 5'd1, 1'b0};
      vecs[8]  = '{32'h40009093, 32'h00000007, 32'h00000008, 5'd1, 5'd0,  NOP,  32'h00000000, 32'h00000000, 5'd1, 1'b1};
      vecs[9]  = '{32'h7FF0C413, 32'h00000003, 32'h00000004, 5'd1, 5'd31, XORI, 32'h00000003, 32'h000007FF, 5'd8, 1'b0};
      vecs[10] = '{32'h40209133, 32'h00000009, 32'h0000000A, 5'd1, 5'd2,  NOP,  32'h00000000, 32'h00000000, 5'd2, 1'b1};

      // reset
      tick();
      tick();
      chk_reset_outputs("por");
      rst_ni = 1'b1;

      // decode stream, output always ready
      out_ready_i = 1'b1;
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].word, vecs[i].r1, vecs[i].r2);
         #1;
         chk($sformatf("v%0d_rs1_addr", i), rs1_addr_o, vecs[i].a1);
         chk($sformatf("v%0d_rs2_addr", i), rs2_addr_o, vecs[i].a2);
         tick();
         chk($sformatf("v%0d_valid", i),   out_valid_o, 32'd1);
         chk($sformatf("v%0d_inst", i),    out_inst_o, vecs[i].inst);
         chk($sformatf("v%0d_a", i),       out_operand_a_o, vecs[i].a);
         chk($sformatf("v%0d_b", i),       out_operand_b_o, vecs[i].b);
         chk($sformatf("v%0d_rd", i),      out_rd_o, vecs[i].rd);
         chk($sformatf("v%0d_illegal", i), out_illegal_o, vecs[i].ill);
      end
      in_valid_i = 1'b0;
      tick();
      chk("drain_valid", out_valid_o, 32'd0);

      // backpressure: three back-to-back words, ALU stalled
      out_ready_i = 1'b0;
      drive(32'h0020C1B3, 32'h00000001, 32'h00000002);
      chk("bp_ready0", in_ready_o, 32'd1);
      tick();
      drive(32'h4020D233, 32'h00000003, 32'h00000004);
      chk("bp_ready1", in_ready_o, 32'd1);
      tick();
      drive(32'h00209133, 32'h00000005, 32'h00000006);
      chk("bp_ready2", in_ready_o, 32'd0);
      tick();
      chk("bp_ready3", in_ready_o, 32'd0);
      chk("bp_hold_inst", out_inst_o, XOR);
      chk("bp_hold_a", out_operand_a_o, 32'h00000001);
      out_ready_i = 1'b1;
      tick();
      chk("bp_out1_inst", out_inst_o, SRA);
      chk("bp_out1_a", out_operand_a_o, 32'h00000003);
      chk("bp_out1_b", out_operand_b_o, 32'h00000004);
      chk("bp_ready4", in_ready_o, 32'd1);
      tick();
      in_valid_i = 1'b0;
      chk("bp_out2_inst", out_inst_o, SLL);
      chk("bp_out2_a", out_operand_a_o, 32'h00000005);
      chk("bp_out2_b", out_operand_b_o, 32'h00000006);
      chk("bp_out2_valid", out_valid_o, 32'd1);
      tick();
      chk("bp_empty", out_valid_o, 32'd0);

      // flush while TWO with an input pending
      out_ready_i = 1'b0;
      drive(32'h0020C1B3, 32'h00000001, 32'h00000002);
      tick();
      drive(32'h4020D233, 32'h00000003, 32'h00000004);
      tick();
      chk("fl_two_ready", in_ready_o, 32'd0);
      flush_i = 1'b1;
      drive(32'h00209133, 32'h00000005, 32'h00000006);
      tick();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      chk("fl_valid", out_valid_o, 32'd0);
      chk("fl_ready", in_ready_o, 32'd1);
      out_ready_i = 1'b1;
      tick();
      chk("fl_gone", out_valid_o, 32'd0);

      // flush in ONE discards a word firing in the same cycle
      out_ready_i = 1'b0;
      drive(32'h0020C1B3, 32'h00000001, 32'h00000002);
      tick();
      flush_i = 1'b1;
      drive(32'h4020D233, 32'h00000003, 32'h00000004);
      tick();
      flush_i = 1'b0;
      chk("fl1_valid", out_valid_o, 32'd0);
      out_ready_i = 1'b1;
      drive(32'h00209133, 32'h00000005, 32'h00000006);
      tick();
      in_valid_i = 1'b0;
      chk("fl1_next_inst", out_inst_o, SLL);
      chk("fl1_next_a", out_operand_a_o, 32'h00000005);
      tick();
      chk("fl1_empty", out_valid_o, 32'd0);

      // reset while TWO
      out_ready_i = 1'b0;
      drive(32'h0020C1B3, 32'h00000001, 32'h00000002);
      tick();
      drive(32'h4020D233, 32'h00000003, 32'h00000004);
      tick();
      chk("rst_two_ready", in_ready_o, 32'd0);
      rst_ni = 1'b0;
      in_valid_i = 1'b0;
      tick();
      chk_reset_outputs("rst");
      rst_ni = 1'b1;
      out_ready_i = 1'b1;
      tick();
      chk("rst_after_valid", out_valid_o, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
